// File: rtl/i2s_dac_player.sv
// rtl/i2s_dac_player.sv - WM8731 DAC-side I2S master: clocks, per-frame fetch, MSB-first mono serialiser
//
// Ports:
//   i_clk            system clock, all logic on rising edge
//   i_rst            asynchronous active-high reset
//   i_play           high while the player is in PLAY
//   i_read_data      sample returned by the SRAM read stage
//   i_readdata_done  1-cycle strobe, i_read_data valid this cycle
//   i_read_finished  level, read stage reached the end of the recording
//   o_read_enable    1-cycle sample request, issued at the right-channel start
//   o_bclk           AUD_BCLK
//   o_daclrck        AUD_DACLRCK (0 = left, 1 = right)
//   o_dacdat         AUD_DACDAT
//   o_underrun       sticky, a frame started without a sample
//   o_play_done      1-cycle pulse when the end of the recording is reached
module i2s_dac_player #(
  parameter int CLK_PER_BCLK = 4,
  parameter int BITS_PER_CH  = 32,
  parameter int DATA_W       = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_play,
  input  logic [DATA_W-1:0] i_read_data,
  input  logic              i_readdata_done,
  input  logic              i_read_finished,
  output logic              o_read_enable,
  output logic              o_bclk,
  output logic              o_daclrck,
  output logic              o_dacdat,
  output logic              o_underrun,
  output logic              o_play_done
);

  localparam int PH_W  = (CLK_PER_BCLK > 2) ? $clog2(CLK_PER_BCLK) : 1;
  localparam int SL_W  = (BITS_PER_CH > 2) ? $clog2(BITS_PER_CH) : 1;
  localparam int IDX_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_PER_BCLK - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(CLK_PER_BCLK / 2);
  localparam logic [SL_W-1:0] SL_LAST = SL_W'(BITS_PER_CH - 1);

  typedef enum logic [1:0] {
    F_IDLE  = 2'd0,
    F_WAIT  = 2'd1,
    F_READY = 2'd2
  } fetch_t;

  logic [PH_W-1:0]   phase_q, phase_d;
  logic [SL_W-1:0]   slot_q, slot_d;
  logic              bclk_q, bclk_d;
  logic              daclrck_q, daclrck_d;
  logic              dacdat_q, dacdat_d;
  logic [DATA_W-1:0] cur_sample_q, cur_sample_d;
  logic [DATA_W-1:0] next_sample_q, next_sample_d;
  fetch_t            state_q, state_d;
  logic              read_enable_q, read_enable_d;
  logic              underrun_q, underrun_d;
  logic              play_done_q, play_done_d;
  logic              done_flag_q, done_flag_d;

  logic fall;
  logic frame_start;
  logic req_point;

  always_comb begin
    phase_d       = phase_q;
    slot_d        = slot_q;
    daclrck_d     = daclrck_q;
    dacdat_d      = dacdat_q;
    cur_sample_d  = cur_sample_q;
    next_sample_d = next_sample_q;
    state_d       = state_q;
    underrun_d    = underrun_q;
    done_flag_d   = done_flag_q;
    read_enable_d = 1'b0;
    play_done_d   = 1'b0;

    // The cycle whose edge wraps phase back to 0 is the BCLK falling edge.
    fall        = (phase_q == PH_LAST);
    frame_start = fall && (slot_q == SL_LAST) && daclrck_q;
    req_point   = fall && (slot_q == SL_LAST) && !daclrck_q;

    phase_d = fall ? '0 : phase_q + 1'b1;
    bclk_d  = (phase_d >= PH_HALF);

    if (fall) begin
      if (slot_q == SL_LAST) begin
        slot_d    = '0;
        daclrck_d = ~daclrck_q;
      end else begin
        slot_d = slot_q + 1'b1;
      end
      // One-BCLK I2S delay: slot 0 is blank, sample MSB lands in slot 1.
      dacdat_d = 1'b0;
      for (int k = 1; k <= DATA_W; k++) begin
        if (slot_d == SL_W'(k)) begin
          dacdat_d = cur_sample_q[IDX_W'(DATA_W - k)];
        end
      end
    end

    case (state_q)
      F_IDLE: begin
        if (req_point && i_play) begin
          if (!i_read_finished) begin
            read_enable_d = 1'b1;
            state_d       = F_WAIT;
          end else if (!done_flag_q) begin
            play_done_d = 1'b1;
            done_flag_d = 1'b1;
          end
        end
      end
      F_WAIT: begin
        // A strobe coinciding with frame start is late and dropped.
        if (i_readdata_done && !frame_start) begin
          next_sample_d = i_read_data;
          state_d       = F_READY;
        end
      end
      default: ;
    endcase

    if (frame_start) begin
      cur_sample_d = '0;
      if (i_play) begin
        if (state_q == F_READY) begin
          cur_sample_d = next_sample_q;
        end else if (state_q == F_WAIT) begin
          underrun_d = 1'b1;
        end
        state_d = F_IDLE;
      end
    end

    if (!i_play) begin
      state_d     = F_IDLE;
      done_flag_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      phase_q       <= '0;
      slot_q        <= '0;
      bclk_q        <= 1'b0;
      daclrck_q     <= 1'b0;
      dacdat_q      <= 1'b0;
      cur_sample_q  <= '0;
      next_sample_q <= '0;
      state_q       <= F_IDLE;
      read_enable_q <= 1'b0;
      underrun_q    <= 1'b0;
      play_done_q   <= 1'b0;
      done_flag_q   <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      slot_q        <= slot_d;
      bclk_q        <= bclk_d;
      daclrck_q     <= daclrck_d;
      dacdat_q      <= dacdat_d;
      cur_sample_q  <= cur_sample_d;
      next_sample_q <= next_sample_d;
      state_q       <= state_d;
      read_enable_q <= read_enable_d;
      underrun_q    <= underrun_d;
      play_done_q   <= play_done_d;
      done_flag_q   <= done_flag_d;
    end
  end

  assign o_read_enable = read_enable_q;
  assign o_bclk        = bclk_q;
  assign o_daclrck     = daclrck_q;
  assign o_dacdat      = dacdat_q;
  assign o_underrun    = underrun_q;
  assign o_play_done   = play_done_q;

endmodule

// File: tb/tb_i2s_dac_player.sv
// tb/tb_i2s_dac_player.sv - scoreboard bench for i2s_dac_player
module tb_i2s_dac_player;

  localparam int FRAME = 256;
  localparam int HALF  = 128;
  localparam int BIG   = 32'h7fffffff;

  logic        clk;
  logic        rst;
  logic        i_play;
  logic [15:0] i_read_data;
  logic        i_readdata_done;
  logic        i_read_finished;
  logic        o_read_enable;
  logic        o_bclk;
  logic        o_daclrck;
  logic        o_dacdat;
  logic        o_underrun;
  logic        o_play_done;

  i2s_dac_player dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_play          (i_play),
    .i_read_data     (i_read_data),
    .i_readdata_done (i_readdata_done),
    .i_read_finished (i_read_finished),
    .o_read_enable   (o_read_enable),
    .o_bclk          (o_bclk),
    .o_daclrck       (o_daclrck),
    .o_dacdat        (o_dacdat),
    .o_underrun      (o_underrun),
    .o_play_done     (o_play_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since reset release; state n is the state after the n-th edge.
  int n;
  always @(posedge clk or posedge rst) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, n, got, exp);
    end
  endtask

  typedef struct {
    int          frame;
    logic [15:0] sample;
  } exp_t;

  exp_t        exp_q[$];
  int          exp_under_n = BIG;
  int          mode = 0;
  logic        use_fixed = 1'b1;
  logic [15:0] fixed_data = 16'hA5C3;
  int          spur_req = 0;
  int          spur_done = 0;

  // Responder: models the SRAM read stage and records what each frame must play.
  initial begin
    int          cd;
    int          k;
    logic [15:0] pend;
    cd = -1;
    pend = '0;
    i_readdata_done = 1'b0;
    i_read_data = '0;
    forever begin
      @(negedge clk);
      i_readdata_done = 1'b0;
      if (rst) begin
        exp_q.delete();
        cd = -1;
        exp_under_n = BIG;
        spur_done = spur_req;
      end else begin
        if (o_read_enable) begin
          k = n / FRAME;
          pend = use_fixed ? fixed_data : 16'($urandom);
          if (mode == 0) begin
            exp_q.push_back('{frame: k + 1, sample: pend});
            cd = 3;
          end else begin
            if (exp_under_n > FRAME * (k + 1)) exp_under_n = FRAME * (k + 1);
            cd = FRAME * (k + 1) + 10 - n;
          end
        end else if (cd > 0) begin
          cd--;
        end
        if (cd == 0) begin
          i_read_data = pend;
          i_readdata_done = 1'b1;
          cd = -1;
        end else if (cd < 0 && spur_req != spur_done) begin
          i_read_data = 16'hFFFF;
          i_readdata_done = 1'b1;
          spur_done++;
        end
      end
    end
  end

  // Monitor: frame-level I2S reference and per-cycle control checks.
  initial begin
    logic        prev_play;
    logic        prev_fin;
    logic        flag;
    logic [63:0] bits;
    logic [15:0] es;
    int          pos;
    int          f;
    logic        exp_re;
    logic        exp_pd;
    prev_play = 1'b0;
    prev_fin = 1'b0;
    flag = 1'b0;
    bits = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_play = 1'b0;
        prev_fin = 1'b0;
        flag = 1'b0;
        bits = '0;
      end else begin
        pos = n % FRAME;
        check("clocks", 64'({o_bclk, o_daclrck}),
              64'({1'((n % 4) >= 2), 1'((n / HALF) % 2)}));
        exp_re = (pos == HALF) && prev_play && !prev_fin;
        exp_pd = (pos == HALF) && prev_play && prev_fin && !flag;
        check("read_enable", 64'(o_read_enable), 64'(exp_re));
        check("play_done", 64'(o_play_done), 64'(exp_pd));
        check("underrun", 64'(o_underrun), 64'(n >= exp_under_n));
        if (!prev_play) flag = 1'b0;
        else if (exp_pd) flag = 1'b1;
        prev_play = i_play;
        prev_fin = i_read_finished;
        if ((n % 4) == 2) bits[63 - pos / 4] = o_dacdat;
        if (pos == FRAME - 1) begin
          f = n / FRAME;
          es = '0;
          while (exp_q.size() > 0 && exp_q[0].frame < f) begin
            check("stale_entry", 64'(exp_q[0].frame), 64'(f));
            void'(exp_q.pop_front());
          end
          if (exp_q.size() > 0 && exp_q[0].frame == f) es = exp_q.pop_front().sample;
          check("frame_bits", bits, {1'b0, es, 15'b0, 1'b0, es, 15'b0});
        end
      end
    end
  end

  task automatic goto(input int pos);
    int guard;
    guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while ((n % FRAME) != pos && guard < 1000);
    check("goto_bound", 64'(guard < 1000), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog at cycle %0d: got timeout expected finish", n);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    i_play = 1'b0;
    i_read_finished = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          64'({o_bclk, o_daclrck, o_dacdat, o_read_enable, o_underrun, o_play_done}), 64'(0));
    rst = 1'b0;

    // Idle clocks, silent output.
    repeat (600) @(posedge clk);

    // Normal playback, fixed then random samples.
    goto(10);
    i_play = 1'b1;
    goto(10);
    goto(10);
    use_fixed = 1'b0;
    goto(10);
    goto(10);

    // Stray done strobes while no request is outstanding.
    goto(10);
    i_play = 1'b0;
    goto(20);
    spur_req++;
    goto(10);
    i_play = 1'b1;
    use_fixed = 1'b1;
    fixed_data = 16'h1234;
    goto(40);
    spur_req++;
    goto(10);
    use_fixed = 1'b0;

    // One withheld sample, late done at +10 into the next frame.
    mode = 1;
    goto(140);
    mode = 0;
    goto(10);
    goto(10);
    goto(10);

    // End of recording.
    i_read_finished = 1'b1;
    goto(10);
    goto(10);
    goto(10);
    i_play = 1'b0;
    goto(20);
    i_play = 1'b1;
    goto(10);
    goto(10);

    // Reset mid-slot 8 of a left channel playing A5C3.
    i_read_finished = 1'b0;
    use_fixed = 1'b1;
    fixed_data = 16'hA5C3;
    goto(10);
    goto(34);
    check("pre_reset_dacdat", 64'(o_dacdat), 64'(fixed_data[8]));
    #1;
    rst = 1'b1;
    #1;
    check("async_reset_outputs",
          64'({o_bclk, o_daclrck, o_dacdat, o_read_enable, o_underrun, o_play_done}), 64'(0));
    i_play = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (300) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
